// File: rtl/fifo_drain_if.sv
// Valid/ready stream carrying words out of fifo_drain to a downstream consumer.
interface fifo_drain_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_drain.sv
// Read-side controller for the team fifo: pops words and streams them out through a
// 3-entry buffer. Optional delivered-word counter enabled by FIFO_DRAIN_CNT_EN.
module fifo_drain #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drain_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read,
    fifo_drain_if.master     m_if
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] drained_cnt
`endif
);

    localparam int DEPTH = 3;

    logic [1:0]       r_occ;
    logic [1:0]       r_head;
    logic [1:0]       r_tail;
    logic             r_inflight;
    logic [WIDTH-1:0] r_buf [DEPTH];

    logic             w_pop;
    logic             w_credit_ok;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only issued if every buffered and in-flight word still has a slot.
    assign w_credit_ok = ({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3;
    assign fifo_read   = rst & drain_en & ~fifo_empty & w_credit_ok;

    assign m_if.m_valid = (r_occ != 2'd0);
    assign m_if.m_data  = r_buf[r_head];
    assign w_pop        = m_if.m_valid & m_if.m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ      <= 2'd0;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_inflight <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= fifo_read;
            if (r_inflight) begin
                r_buf[r_tail] <= fifo_data_out;
                r_tail        <= next_ptr(r_tail);
            end
            if (w_pop) begin
                r_head <= next_ptr(r_head);
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_WIDTH-1:0] r_drained_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drained_cnt <= '0;
        end else if (w_pop) begin
            r_drained_cnt <= r_drained_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign drained_cnt = r_drained_cnt;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: behavioural DEPTH=4 fifo plus a credit/queue reference model.
module tb_fifo_drain;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 16;
    localparam int FDEPTH    = 4;

    logic             clk;
    logic             rst;
    logic             drain_en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_read;
`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_WIDTH-1:0] drained_cnt;
`endif

    fifo_drain_if #(.WIDTH(WIDTH)) sif ();

    fifo_drain #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .drain_en      (drain_en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read),
        .m_if          (sif)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .drained_cnt   (drained_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural fifo: registered read data, one cycle after fifo_read.
    logic [WIDTH-1:0] fq[$];
    logic [WIDTH-1:0] pend[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_data_out <= '0;
        end else if (fifo_read && fq.size() != 0) begin
            fifo_data_out <= fq.pop_front();
            fifo_empty    <= (fq.size() == 1);
        end
    end

    // Reference model: outstanding = words read from the fifo and not yet delivered.
    int               outst;
    bit               infl_m;
    logic [WIDTH-1:0] exp_q[$];
    int               cnt_m;
    int               n_chk;
    int               n_err;
    int               dut_pops;
    int               dut_reads;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        outst  = 0;
        infl_m = 1'b0;
        cnt_m  = 0;
        exp_q.delete();
        pend.delete();
        fq.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic step(input bit ready, input bit den);
        int  occ_m;
        bit  exp_rd;
        bit  pop;
        @(negedge clk);
        while (pend.size() != 0 && fq.size() < FDEPTH) begin
            fq.push_back(pend.pop_front());
        end
        fifo_empty   = (fq.size() == 0);
        sif.m_ready  = ready;
        drain_en     = den;
        #1;
        occ_m  = outst - int'(infl_m);
        exp_rd = den && (fq.size() != 0) && (outst < 3);
        chk("fifo_read", 32'(fifo_read), 32'(exp_rd));
        chk("m_valid", 32'(sif.m_valid), 32'(occ_m > 0));
        if (occ_m > 0) chk("m_data", 32'(sif.m_data), 32'(exp_q[0]));
`ifdef FIFO_DRAIN_CNT_EN
        chk("drained_cnt", 32'(drained_cnt), 32'(cnt_m % (1 << CNT_WIDTH)));
`endif
        if (fifo_read) dut_reads++;
        if (sif.m_valid && sif.m_ready) dut_pops++;
        pop = (occ_m > 0) && ready;
        if (exp_rd) exp_q.push_back(fq[0]);
        if (pop) begin
            void'(exp_q.pop_front());
            cnt_m++;
        end
        outst  = outst + int'(exp_rd) - int'(pop);
        infl_m = exp_rd;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(sif.m_valid), 32'd0);
        chk({tag, "_read"}, 32'(fifo_read), 32'd0);
        chk({tag, "_data"}, 32'(sif.m_data), 32'd0);
`ifdef FIFO_DRAIN_CNT_EN
        chk({tag, "_cnt"}, 32'(drained_cnt), 32'd0);
`endif
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load4();
        pend.push_back(16'd5);
        pend.push_back(16'd4);
        pend.push_back(16'd3);
        pend.push_back(16'd2);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0;
        drain_en = 1'b0;
        sif.m_ready = 1'b0;
        clear_model();

        // Reset state
        do_reset("rst0");

        // Continuous drain of 5,4,3,2
        load4();
        step(1'b1, 1'b0);
        dut_reads = 0;
        dut_pops  = 0;
        repeat (8) step(1'b1, 1'b1);
        chk("t2_reads", 32'(dut_reads), 32'd4);
        chk("t2_pops", 32'(dut_pops), 32'd4);
        chk("t2_empty", 32'(fifo_empty), 32'd1);
`ifdef FIFO_DRAIN_CNT_EN
        chk("t6_cnt4", 32'(drained_cnt), 32'd4);
`endif

        // Stalled consumer: only three reads fit the buffer
        load4();
        step(1'b0, 1'b0);
        dut_reads = 0;
        dut_pops  = 0;
        repeat (6) step(1'b0, 1'b1);
        chk("t3_reads", 32'(dut_reads), 32'd3);
        chk("t3_fifo_left", 32'(fq.size()), 32'd1);
        chk("t3_head", 32'(sif.m_data), 32'd5);
        repeat (8) step(1'b1, 1'b1);
        chk("t3_pops", 32'(dut_pops), 32'd4);

        // drain_en low blocks reads
        load4();
        dut_reads = 0;
        repeat (5) step(1'b1, 1'b0);
        chk("t4_reads", 32'(dut_reads), 32'd0);
        chk("t4_valid", 32'(sif.m_valid), 32'd0);
        repeat (8) step(1'b1, 1'b1);

        // Async reset mid-stream after two deliveries
        load4();
        dut_pops = 0;
        for (int i = 0; i < 20 && dut_pops < 2; i++) step(1'b1, 1'b1);
        chk("t5_two_pops", 32'(dut_pops >= 2), 32'd1);
        do_reset("t5");
        repeat (4) step(1'b1, 1'b1);
        chk("t5_valid_after", 32'(sif.m_valid), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && pend.size() < 4) pend.push_back(16'($urandom));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0));
            if (i == 200) do_reset("rnd");
        end
        repeat (12) step(1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
